// File: rtl/multi_cycle_controller_if.sv
// rtl/multi_cycle_controller_if.sv - controller <-> datapath/memory strobe and handshake bundle
interface multi_cycle_controller_if;
  logic [15:0] ir;
  logic        flag_z;
  logic        mem_ack;
  logic        ir_ld, pc_inc, pc_off_ld;
  logic        a_ld, b_ld, z_ld, mdr_ld, flags_ld;
  logic [2:0]  pa;
  logic        rdr;
  logic [2:0]  wp;
  logic        wrr;
  logic        wb_sel;
  logic [2:0]  fsel;
  logic        mem_req, mem_we, addr_sel;
  logic        halted, bus_err, illegal_op;

  modport master (
    input  ir, flag_z, mem_ack,
    output ir_ld, pc_inc, pc_off_ld, a_ld, b_ld, z_ld, mdr_ld, flags_ld,
           pa, rdr, wp, wrr, wb_sel, fsel, mem_req, mem_we, addr_sel,
           halted, bus_err, illegal_op
  );

  modport slave (
    output ir, flag_z, mem_ack,
    input  ir_ld, pc_inc, pc_off_ld, a_ld, b_ld, z_ld, mdr_ld, flags_ld,
           pa, rdr, wp, wrr, wb_sel, fsel, mem_req, mem_we, addr_sel,
           halted, bus_err, illegal_op
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - Moore FSM sequencing the 16-bit multi-cycle datapath
module multi_cycle_controller #(
  parameter int ACK_TIMEOUT = 15,
  parameter int OP_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_cycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_RDA, S_RDB, S_EXEC, S_WB, S_MEMRD, S_WBM,
    S_MEMWR, S_BRANCH, S_HALT, S_HALT_BUS, S_HALT_ILL
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BZ   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BRA  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

  state_t          state, nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [OP_W-1:0] op;
  logic [2:0]      rd, rs1, rs2;
  logic            tmo;
  logic            unused_ir;

  assign op        = bus.ir[15 -: OP_W];
  assign rd        = bus.ir[11:9];
  assign rs1       = bus.ir[8:6];
  assign rs2       = bus.ir[5:3];
  assign unused_ir = ^bus.ir[2:0];
  // Ack is checked before tmo, so a coincident ack always wins.
  assign tmo       = (cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = '0;
    case (state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (bus.mem_ack) begin
          if (state == S_FETCH)      nxt = S_DECODE;
          else if (state == S_MEMRD) nxt = S_WBM;
          else                       nxt = S_FETCH;
        end else if (tmo) begin
          nxt = S_HALT_BUS;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (op <= OP_ST)                     nxt = S_RDA;
        else if (op == OP_BZ || op == OP_BRA) nxt = S_BRANCH;
        else if (op == OP_HALT)              nxt = S_HALT;
        else                                 nxt = S_HALT_ILL;
      end
      S_RDA: begin
        if (op == OP_NEG || op == OP_MOV) nxt = S_EXEC;
        else if (op == OP_LD)             nxt = S_MEMRD;
        else                              nxt = S_RDB;
      end
      S_RDB:    nxt = (op == OP_ST) ? S_MEMWR : S_EXEC;
      S_EXEC:   nxt = S_WB;
      S_WB:     nxt = S_FETCH;
      S_WBM:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end

  // Strobes are forced low while reset is held so a pending transfer drops at once.
  always_comb begin
    bus.ir_ld      = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_off_ld  = 1'b0;
    bus.a_ld       = 1'b0;
    bus.b_ld       = 1'b0;
    bus.z_ld       = 1'b0;
    bus.mdr_ld     = 1'b0;
    bus.flags_ld   = 1'b0;
    bus.pa         = 3'd0;
    bus.rdr        = 1'b0;
    bus.wp         = 3'd0;
    bus.wrr        = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.fsel       = 3'd0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.addr_sel   = 1'b0;
    bus.halted     = 1'b0;
    bus.bus_err    = 1'b0;
    bus.illegal_op = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_ld   = bus.mem_ack;
          bus.pc_inc  = bus.mem_ack;
        end
        S_RDA: begin
          bus.pa   = rs1;
          bus.rdr  = 1'b1;
          bus.a_ld = 1'b1;
        end
        S_RDB: begin
          bus.pa   = (op == OP_ST) ? rd : rs2;
          bus.rdr  = 1'b1;
          bus.b_ld = 1'b1;
        end
        S_EXEC: begin
          bus.z_ld     = 1'b1;
          bus.flags_ld = 1'b1;
          case (op)
            OP_ADD:  bus.fsel = 3'b000;
            OP_SUB:  bus.fsel = 3'b001;
            OP_OR:   bus.fsel = 3'b010;
            OP_AND:  bus.fsel = 3'b011;
            OP_NEG:  bus.fsel = 3'b100;
            OP_MOV:  bus.fsel = 3'b110;
            default: bus.fsel = 3'b000;
          endcase
        end
        S_WB: begin
          bus.wp  = rd;
          bus.wrr = 1'b1;
        end
        S_MEMRD: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          bus.mdr_ld   = bus.mem_ack;
        end
        S_WBM: begin
          bus.wp     = rd;
          bus.wrr    = 1'b1;
          bus.wb_sel = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = 1'b1;
          bus.addr_sel = 1'b1;
        end
        S_BRANCH:   bus.pc_off_ld = (op == OP_BRA) || (op == OP_BZ && bus.flag_z);
        S_HALT:     bus.halted = 1'b1;
        S_HALT_BUS: begin
          bus.halted  = 1'b1;
          bus.bus_err = 1'b1;
        end
        S_HALT_ILL: begin
          bus.halted     = 1'b1;
          bus.illegal_op = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - per-cycle vector table plus reset/halt/timeout sequences
module tb_multi_cycle_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_controller_if bus();

  multi_cycle_controller #(.ACK_TIMEOUT(15), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Packed output word: ir_ld pc_inc pc_off_ld a_ld b_ld z_ld mdr_ld flags_ld
  // pa[3] rdr wp[3] wrr wb_sel fsel[3] mem_req mem_we addr_sel halted bus_err illegal_op
  localparam logic [25:0] NONE      = 26'd0;
  localparam logic [25:0] IR_LD     = 26'd1 << 25;
  localparam logic [25:0] PC_INC    = 26'd1 << 24;
  localparam logic [25:0] PC_OFF_LD = 26'd1 << 23;
  localparam logic [25:0] A_LD      = 26'd1 << 22;
  localparam logic [25:0] B_LD      = 26'd1 << 21;
  localparam logic [25:0] Z_LD      = 26'd1 << 20;
  localparam logic [25:0] MDR_LD    = 26'd1 << 19;
  localparam logic [25:0] FLAGS_LD  = 26'd1 << 18;
  localparam logic [25:0] RDR       = 26'd1 << 14;
  localparam logic [25:0] WRR       = 26'd1 << 10;
  localparam logic [25:0] WB_SEL    = 26'd1 << 9;
  localparam logic [25:0] MEM_REQ   = 26'd1 << 5;
  localparam logic [25:0] MEM_WE    = 26'd1 << 4;
  localparam logic [25:0] ADDR_SEL  = 26'd1 << 3;
  localparam logic [25:0] HALTED    = 26'd1 << 2;
  localparam logic [25:0] BUS_ERR   = 26'd1 << 1;
  localparam logic [25:0] ILL_OP    = 26'd1;

  function automatic logic [25:0] f_pa(input logic [2:0] v);
    return 26'(v) << 15;
  endfunction
  function automatic logic [25:0] f_wp(input logic [2:0] v);
    return 26'(v) << 11;
  endfunction
  function automatic logic [25:0] f_fs(input logic [2:0] v);
    return 26'(v) << 6;
  endfunction

  function automatic logic [25:0] outs();
    return {bus.ir_ld, bus.pc_inc, bus.pc_off_ld, bus.a_ld, bus.b_ld, bus.z_ld,
            bus.mdr_ld, bus.flags_ld, bus.pa, bus.rdr, bus.wp, bus.wrr, bus.wb_sel,
            bus.fsel, bus.mem_req, bus.mem_we, bus.addr_sel, bus.halted,
            bus.bus_err, bus.illegal_op};
  endfunction

  typedef struct {
    logic [15:0] ir;
    logic        fz;
    logic        ack;
    logic [25:0] exp;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic [15:0] i, input logic f, input logic a,
                              input logic [25:0] e);
    vec_t v;
    v.ir = i; v.fz = f; v.ack = a; v.exp = e;
    tv.push_back(v);
  endfunction

  task automatic check(input string name, input logic [25:0] exp);
    logic [25:0] got;
    got = outs();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h required %h", name, got, exp);
    end
  endtask

  // Called at a negedge: drive, check settled outputs, then step past one posedge.
  task automatic apply(input logic [15:0] i, input logic f, input logic a,
                       input logic [25:0] e, input string name);
    bus.ir = i; bus.flag_z = f; bus.mem_ack = a;
    #1;
    check(name, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    check("reset_outputs", NONE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [25:0] FET = MEM_REQ | IR_LD | PC_INC;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ir = 16'h0000; bus.flag_z = 1'b0; bus.mem_ack = 1'b0;
    // ADD r1,r2,r3 ; ack in DECODE is ignored
    add(16'h0298, 0, 1, FET);
    add(16'h0298, 0, 1, NONE);
    add(16'h0298, 0, 0, f_pa(2) | RDR | A_LD);
    add(16'h0298, 0, 0, f_pa(3) | RDR | B_LD);
    add(16'h0298, 0, 0, f_fs(3'b000) | Z_LD | FLAGS_LD);
    add(16'h0298, 0, 0, f_wp(1) | WRR);
    // SUB r1,r2,r3
    add(16'h1298, 0, 1, FET);
    add(16'h1298, 0, 0, NONE);
    add(16'h1298, 0, 0, f_pa(2) | RDR | A_LD);
    add(16'h1298, 0, 0, f_pa(3) | RDR | B_LD);
    add(16'h1298, 0, 0, f_fs(3'b001) | Z_LD | FLAGS_LD);
    add(16'h1298, 0, 0, f_wp(1) | WRR);
    // AND r7,r6,r5
    add(16'h3FA8, 0, 1, FET);
    add(16'h3FA8, 0, 0, NONE);
    add(16'h3FA8, 0, 0, f_pa(6) | RDR | A_LD);
    add(16'h3FA8, 0, 0, f_pa(5) | RDR | B_LD);
    add(16'h3FA8, 0, 0, f_fs(3'b011) | Z_LD | FLAGS_LD);
    add(16'h3FA8, 0, 0, f_wp(7) | WRR);
    // NEG r5,r4 (5 cycles)
    add(16'h4B00, 0, 1, FET);
    add(16'h4B00, 0, 0, NONE);
    add(16'h4B00, 0, 0, f_pa(4) | RDR | A_LD);
    add(16'h4B00, 0, 0, f_fs(3'b100) | Z_LD | FLAGS_LD);
    add(16'h4B00, 0, 0, f_wp(5) | WRR);
    // MOV r5,r4
    add(16'h5B00, 0, 1, FET);
    add(16'h5B00, 0, 0, NONE);
    add(16'h5B00, 0, 0, f_pa(4) | RDR | A_LD);
    add(16'h5B00, 0, 0, f_fs(3'b110) | Z_LD | FLAGS_LD);
    add(16'h5B00, 0, 0, f_wp(5) | WRR);
    // LD r2,[r2] with 3 wait cycles
    add(16'h6480, 0, 1, FET);
    add(16'h6480, 0, 0, NONE);
    add(16'h6480, 0, 0, f_pa(2) | RDR | A_LD);
    add(16'h6480, 0, 0, MEM_REQ | ADDR_SEL);
    add(16'h6480, 0, 0, MEM_REQ | ADDR_SEL);
    add(16'h6480, 0, 0, MEM_REQ | ADDR_SEL);
    add(16'h6480, 0, 1, MEM_REQ | ADDR_SEL | MDR_LD);
    add(16'h6480, 0, 0, f_wp(2) | WRR | WB_SEL);
    // ST r3,[r1] with one wait cycle in FETCH
    add(16'h7640, 0, 0, MEM_REQ);
    add(16'h7640, 0, 1, FET);
    add(16'h7640, 0, 0, NONE);
    add(16'h7640, 0, 0, f_pa(1) | RDR | A_LD);
    add(16'h7640, 0, 0, f_pa(3) | RDR | B_LD);
    add(16'h7640, 0, 1, MEM_REQ | MEM_WE | ADDR_SEL);
    // BZ not taken, BZ taken, BRA with flag clear
    add(16'h8005, 0, 1, FET);
    add(16'h8005, 0, 0, NONE);
    add(16'h8005, 0, 0, NONE);
    add(16'h8005, 1, 1, FET);
    add(16'h8005, 1, 0, NONE);
    add(16'h8005, 1, 0, PC_OFF_LD);
    add(16'h9000, 0, 1, FET);
    add(16'h9000, 0, 0, NONE);
    add(16'h9000, 0, 0, PC_OFF_LD);
    add(16'h0298, 0, 0, MEM_REQ);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < tv.size(); i++)
      apply(tv[i].ir, tv[i].fz, tv[i].ack, tv[i].exp, $sformatf("vec[%0d]", i));

    // Reset asserted while MEMRD waits for ack
    do_reset();
    apply(16'h6480, 0, 1, FET, "rst_ld_fetch");
    apply(16'h6480, 0, 0, NONE, "rst_ld_decode");
    apply(16'h6480, 0, 0, f_pa(2) | RDR | A_LD, "rst_ld_rda");
    apply(16'h6480, 0, 0, MEM_REQ | ADDR_SEL, "rst_ld_memrd");
    rst_n = 1'b0;
    #1;
    check("mid_memrd_reset", NONE);
    @(negedge clk);
    rst_n = 1'b1;
    apply(16'h6480, 0, 0, MEM_REQ, "after_reset_fetch");

    // Illegal opcode halts with illegal_op, ignoring ack
    do_reset();
    apply(16'hB000, 0, 1, FET, "ill_fetch");
    apply(16'hB000, 0, 0, NONE, "ill_decode");
    for (int i = 0; i < 20; i++)
      apply(16'hB000, i[0], i[1], HALTED | ILL_OP, $sformatf("ill_halt[%0d]", i));

    // HALT opcode
    do_reset();
    apply(16'hF000, 0, 1, FET, "halt_fetch");
    apply(16'hF000, 0, 0, NONE, "halt_decode");
    for (int i = 0; i < 3; i++)
      apply(16'hF000, 0, 1, HALTED, $sformatf("halt[%0d]", i));

    // Ack never arrives: 15 request cycles, then bus error
    do_reset();
    for (int i = 0; i < 15; i++)
      apply(16'h9000, 0, 0, MEM_REQ, $sformatf("tmo_wait[%0d]", i));
    apply(16'h9000, 0, 0, HALTED | BUS_ERR, "tmo_halt");
    apply(16'h9000, 0, 1, HALTED | BUS_ERR, "tmo_sticky");

    // Ack on the 15th cycle beats the timeout
    do_reset();
    for (int i = 0; i < 14; i++)
      apply(16'h9000, 0, 0, MEM_REQ, $sformatf("late_wait[%0d]", i));
    apply(16'h9000, 0, 1, FET, "late_ack");
    apply(16'h9000, 0, 0, NONE, "late_decode");
    apply(16'h9000, 0, 0, PC_OFF_LD, "late_branch");
    apply(16'h9000, 0, 0, MEM_REQ, "late_refetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
